mem_port_arbiter: RTL and testbench

Shares the single data/instruction memory port between the multicycle RISC-V core (requester C) and a debug/program-loader master (requester D).
- Two-way round-robin arbitration.
- Latches the winning request and drives the memory with fixed latency.
- Returns read data with a one-cycle ready pulse.
- The core sequences every memory access through this block's req/ready handshake instead of driving memory directly.

---
 rtl/mem_arb_pkg.sv | 42 ++++
 rtl/rr_arb2.sv | 39 +++
 rtl/mem_port_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
//   state_t      - arbiter FSM states
//   OWN_*        - owner encodings (core / debug master)
//   F3_*         - RISC-V load/store funct3 encodings passed to byte-lane logic
//   MEM_LAT_*    - legal memory latency range; lat_load() turns a latency into
//                  the down-counter load value, clamped into that range
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DBG  = 1'b1;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;
    localparam int CNT_W       = 2;

    // Counter load value for a given latency; out-of-range latencies clamp.
    function automatic logic [CNT_W-1:0] lat_load(input int lat);
        if (lat < MEM_LAT_MIN) begin
            lat_load = {CNT_W{1'b0}};
        end else if (lat > MEM_LAT_MAX) begin
            lat_load = CNT_W'(MEM_LAT_MAX - 1);
        end else begin
            lat_load = CNT_W'(lat - 1);
        end
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker.
//   req[0] = core, req[1] = debug master
//   last_grant  - id of the previously granted requester
//   grant_valid - at least one request present
//   grant_id    - winner (OWN_CORE / OWN_DBG); on a tie, the one not granted last
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    // Winner selection from the request vector and previous grant.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = last_grant;
        case (req)
            2'b01: begin
                grant_valid = 1'b1;
                grant_id    = OWN_CORE;
            end
            2'b10: begin
                grant_valid = 1'b1;
                grant_id    = OWN_DBG;
            end
            2'b11: begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant;
            end
            default: begin
                grant_valid = 1'b0;
                grant_id    = last_grant;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the core (C) and a
// debug/program-loader master (D) with round-robin arbitration.
//   clk, reset (async, active low)
//   c_* / d_*  : requester handshake (req held until ready; ready is a
//                one-cycle pulse; rdata holds until that requester's next read)
//   mem_*      : memory port, driven from latched request registers;
//                mem_rdata is sampled MEM_LAT cycles after mem_adr is presented
//   busy       : transaction in flight (ACCESS or DONE)
//   owner      : requester of the current/last transaction (0 core, 1 debug)
// Optional build macro MEM_ARB_LOCK_EN: debug master may lock the bus via d_lock.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_adr,
    input  logic [DW-1:0] c_wdata,
    input  logic [2:0]    c_funct3,
    output logic [DW-1:0] c_rdata,
    output logic          c_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_adr,
    input  logic [DW-1:0] d_wdata,
    input  logic [2:0]    d_funct3,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    input  logic          d_lock,
    output logic [AW-1:0] mem_adr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    output logic [2:0]    mem_funct3,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    localparam logic [CNT_W-1:0] LAT_LOAD = lat_load(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_s;
    logic             start_s;
    logic             finish_s;
    logic             release_s;
    logic [1:0]       req_s;
    logic             grant_valid_s;
    logic             grant_id_s;
    logic             last_grant_r;
    logic             we_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sel_we_s;
    logic [AW-1:0]    sel_adr_s;
    logic [DW-1:0]    sel_wdata_s;
    logic [2:0]       sel_funct3_s;

`ifdef MEM_ARB_LOCK_EN
    logic lock_held_r;

    // Lock state: refreshed from d_lock at the end of every debug transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_held_r <= 1'b0;
        end else if (release_s && (owner == OWN_DBG)) begin
            lock_held_r <= d_lock;
        end else begin
            lock_held_r <= lock_held_r;
        end
    end

    // While locked the core request is masked so only the debug master can win.
    always_comb begin
        if (lock_held_r) begin
            req_s = {d_req, 1'b0};
        end else begin
            req_s = {d_req, c_req};
        end
    end
`else
    logic unused_lock_s;
    assign unused_lock_s = d_lock;

    // Plain round-robin request vector.
    always_comb begin
        req_s = {d_req, c_req};
    end
`endif

    rr_arb2 u_rr_arb2 (
        .req         (req_s),
        .last_grant  (last_grant_r),
        .grant_valid (grant_valid_s),
        .grant_id    (grant_id_s)
    );

    // Request field mux toward the latch registers, steered by the winner.
    always_comb begin
        if (grant_id_s == OWN_DBG) begin
            sel_we_s     = d_we;
            sel_adr_s    = d_adr;
            sel_wdata_s  = d_wdata;
            sel_funct3_s = d_funct3;
        end else begin
            sel_we_s     = c_we;
            sel_adr_s    = c_adr;
            sel_wdata_s  = c_wdata;
            sel_funct3_s = c_funct3;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state and transition strobes; requests only matter in IDLE.
    always_comb begin
        state_s   = state_r;
        start_s   = 1'b0;
        finish_s  = 1'b0;
        release_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_valid_s) begin
                    state_s = ACCESS;
                    start_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s  = DONE;
                    finish_s = 1'b1;
                end else begin
                    state_s = ACCESS;
                end
            end
            DONE: begin
                state_s   = IDLE;
                release_s = 1'b1;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Datapath: request latch, latency counter, registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_r <= OWN_DBG;
            owner        <= OWN_CORE;
            we_r         <= 1'b0;
            mem_adr      <= {AW{1'b0}};
            mem_wdata    <= {DW{1'b0}};
            mem_funct3   <= 3'b000;
            mem_we       <= 1'b0;
            cnt_r        <= CNT_ZERO;
            busy         <= 1'b0;
            c_ready      <= 1'b0;
            d_ready      <= 1'b0;
            c_rdata      <= {DW{1'b0}};
            d_rdata      <= {DW{1'b0}};
        end else begin
            // Write strobe only in the first ACCESS cycle.
            mem_we  <= start_s & sel_we_s;
            c_ready <= finish_s & (owner == OWN_CORE);
            d_ready <= finish_s & (owner == OWN_DBG);

            if (start_s) begin
                last_grant_r <= grant_id_s;
                owner        <= grant_id_s;
                we_r         <= sel_we_s;
                mem_adr      <= sel_adr_s;
                mem_wdata    <= sel_wdata_s;
                mem_funct3   <= sel_funct3_s;
                cnt_r        <= LAT_LOAD;
                busy         <= 1'b1;
            end else if ((state_r == ACCESS) && (cnt_r != CNT_ZERO)) begin
                cnt_r <= cnt_r - CNT_ONE;
            end else if (release_s) begin
                busy <= 1'b0;
            end else begin
                cnt_r <= cnt_r;
            end

            // Read data lands in the owner's register on the last ACCESS cycle.
            if (finish_s && !we_r) begin
                if (owner == OWN_DBG) begin
                    d_rdata <= mem_rdata;
                end else begin
                    c_rdata <= mem_rdata;
                end
            end else begin
                c_rdata <= c_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1 (u1) and
// one with MEM_LAT=3 (u3) share all inputs; each check targets one instance.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk;
    logic        reset;
    logic        c_req, c_we, d_req, d_we, d_lock;
    logic [31:0] c_adr, c_wdata, d_adr, d_wdata, mem_rdata;
    logic [2:0]  c_funct3, d_funct3;

    logic [31:0] o1_c_rdata, o1_d_rdata, o1_mem_adr, o1_mem_wdata;
    logic        o1_c_ready, o1_d_ready, o1_mem_we, o1_busy, o1_owner;
    logic [2:0]  o1_mem_funct3;
    logic [31:0] o3_c_rdata, o3_d_rdata, o3_mem_adr, o3_mem_wdata;
    logic        o3_c_ready, o3_d_ready, o3_mem_we, o3_busy, o3_owner;
    logic [2:0]  o3_mem_funct3;

    int total;
    int bad;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u1 (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_wdata(c_wdata),
        .c_funct3(c_funct3), .c_rdata(o1_c_rdata), .c_ready(o1_c_ready),
        .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata),
        .d_funct3(d_funct3), .d_rdata(o1_d_rdata), .d_ready(o1_d_ready),
        .d_lock(d_lock),
        .mem_adr(o1_mem_adr), .mem_we(o1_mem_we), .mem_wdata(o1_mem_wdata),
        .mem_funct3(o1_mem_funct3), .mem_rdata(mem_rdata),
        .busy(o1_busy), .owner(o1_owner)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) u3 (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_wdata(c_wdata),
        .c_funct3(c_funct3), .c_rdata(o3_c_rdata), .c_ready(o3_c_ready),
        .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata),
        .d_funct3(d_funct3), .d_rdata(o3_d_rdata), .d_ready(o3_d_ready),
        .d_lock(d_lock),
        .mem_adr(o3_mem_adr), .mem_we(o3_mem_we), .mem_wdata(o3_mem_wdata),
        .mem_funct3(o3_mem_funct3), .mem_rdata(mem_rdata),
        .busy(o3_busy), .owner(o3_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled at the falling edge.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    // One full read transaction on u1 (ACCESS, DONE, IDLE) with requests held.
    task automatic txn(input string tag, input logic exp_own, input logic [31:0] exp_adr,
                       input logic [31:0] rd);
        tick();
        chk({tag, "_owner"}, {31'd0, o1_owner}, {31'd0, exp_own});
        chk({tag, "_adr"}, o1_mem_adr, exp_adr);
        chk({tag, "_rdy_access"}, {30'd0, o1_d_ready, o1_c_ready}, 32'd0);
        mem_rdata = rd;
        tick();
        chk({tag, "_rdy_done"}, {30'd0, o1_d_ready, o1_c_ready},
            exp_own ? 32'd2 : 32'd1);
        chk({tag, "_rdata"}, exp_own ? o1_d_rdata : o1_c_rdata, rd);
        tick();
        chk({tag, "_idle"}, {29'd0, o1_busy, o1_d_ready, o1_c_ready}, 32'd0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b0;
        c_req    = 1'b0;
        c_we     = 1'b0;
        c_adr    = 32'h0;
        c_wdata  = 32'h0;
        c_funct3 = 3'b000;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_adr    = 32'h0;
        d_wdata  = 32'h0;
        d_funct3 = 3'b000;
        d_lock   = 1'b0;
        mem_rdata = 32'h0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", {31'd0, o1_busy}, 32'd0);
        chk("rst_ready", {30'd0, o1_d_ready, o1_c_ready}, 32'd0);
        chk("rst_we_owner", {30'd0, o1_mem_we, o1_owner}, 32'd0);
        chk("rst_adr", o1_mem_adr, 32'd0);
        chk("rst_c_rdata", o1_c_rdata, 32'd0);
        reset = 1'b1;
        tick();

        // Core read, MEM_LAT=1
        c_req = 1'b1; c_we = 1'b0; c_adr = 32'h40; c_funct3 = F3_LW;
        mem_rdata = 32'hDEADBEEF;
        tick();
        chk("rd_adr", o1_mem_adr, 32'h40);
        chk("rd_busy", {31'd0, o1_busy}, 32'd1);
        chk("rd_owner", {31'd0, o1_owner}, 32'd0);
        chk("rd_no_rdy_early", {31'd0, o1_c_ready}, 32'd0);
        tick();
        chk("rd_c_ready", {31'd0, o1_c_ready}, 32'd1);
        chk("rd_c_rdata", o1_c_rdata, 32'hDEADBEEF);
        chk("rd_busy_done", {31'd0, o1_busy}, 32'd1);
        c_req = 1'b0;
        tick();
        chk("rd_ready_drop", {31'd0, o1_c_ready}, 32'd0);
        chk("rd_busy_drop", {31'd0, o1_busy}, 32'd0);

        // Debug write
        d_req = 1'b1; d_we = 1'b1; d_adr = 32'h100; d_wdata = 32'h12345678;
        d_funct3 = F3_SW; mem_rdata = 32'hCAFEF00D;
        tick();
        chk("wr_we", {31'd0, o1_mem_we}, 32'd1);
        chk("wr_adr", o1_mem_adr, 32'h100);
        chk("wr_wdata", o1_mem_wdata, 32'h12345678);
        chk("wr_funct3", {29'd0, o1_mem_funct3}, 32'd2);
        chk("wr_owner", {31'd0, o1_owner}, 32'd1);
        tick();
        chk("wr_we_once", {31'd0, o1_mem_we}, 32'd0);
        chk("wr_d_ready", {30'd0, o1_d_ready, o1_c_ready}, 32'd2);
        chk("wr_d_rdata_kept", o1_d_rdata, 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        chk("wr_idle", {30'd0, o1_d_ready, o1_busy}, 32'd0);

        // Both requesting continuously: C, D, C, D
        c_req = 1'b1; c_adr = 32'h200; d_req = 1'b1; d_adr = 32'h300;
        txn("rr0", 1'b0, 32'h200, 32'hA0);
        txn("rr1", 1'b1, 32'h300, 32'hA1);
        txn("rr2", 1'b0, 32'h200, 32'hA2);
        txn("rr3", 1'b1, 32'h300, 32'hA3);
        chk("rr_c_rdata_hold", o1_c_rdata, 32'hA2);
        chk("rr_d_rdata_hold", o1_d_rdata, 32'hA3);
        c_req = 1'b0; d_req = 1'b0;

        // Reset during ACCESS of a write
        c_req = 1'b1; c_we = 1'b1; c_adr = 32'h44; c_wdata = 32'h55AA55AA;
        tick();
        chk("rstmid_we_before", {30'd0, o1_mem_we, o1_busy}, 32'd3);
        reset = 1'b0;
        #1;
        chk("rstmid_async", {29'd0, o1_mem_we, o1_busy, o1_c_ready}, 32'd0);
        c_req = 1'b0; c_we = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("rstmid_no_ready", {29'd0, o1_busy, o1_d_ready, o1_c_ready}, 32'd0);
        c_req = 1'b1; c_adr = 32'h48; d_req = 1'b1; d_adr = 32'h348;
        tick();
        chk("rstmid_tie_c", {31'd0, o1_owner}, 32'd0);
        chk("rstmid_tie_adr", o1_mem_adr, 32'h48);
        c_req = 1'b0; d_req = 1'b0;
        tick();
        tick();

        // MEM_LAT=3 read with address change during ACCESS
        pulse_reset();
        c_req = 1'b1; c_we = 1'b0; c_adr = 32'h40; mem_rdata = 32'h11111111;
        tick();
        chk("l3_adr1", o3_mem_adr, 32'h40);
        chk("l3_busy", {31'd0, o3_busy}, 32'd1);
        c_adr = 32'h80; mem_rdata = 32'h22222222;
        tick();
        chk("l3_adr2", o3_mem_adr, 32'h40);
        chk("l3_no_rdy2", {31'd0, o3_c_ready}, 32'd0);
        mem_rdata = 32'h5A5A5A5A;
        tick();
        chk("l3_adr3", o3_mem_adr, 32'h40);
        chk("l3_no_rdy3", {31'd0, o3_c_ready}, 32'd0);
        tick();
        chk("l3_ready", {31'd0, o3_c_ready}, 32'd1);
        chk("l3_rdata", o3_c_rdata, 32'h5A5A5A5A);
        c_req = 1'b0;
        tick();
        chk("l3_idle", {30'd0, o3_busy, o3_c_ready}, 32'd0);

        // Debug lock behaviour
        pulse_reset();
        c_adr = 32'h500; d_adr = 32'h600;
        d_req = 1'b1; d_lock = 1'b1;
        txn("lk0", 1'b1, 32'h600, 32'hB0);
        c_req = 1'b1;
`ifdef MEM_ARB_LOCK_EN
        txn("lk1", 1'b1, 32'h600, 32'hB1);
        d_lock = 1'b0;
        txn("lk2", 1'b1, 32'h600, 32'hB2);
        txn("lk3", 1'b0, 32'h500, 32'hB3);
`else
        txn("lk1", 1'b0, 32'h500, 32'hB1);
        d_lock = 1'b0;
        txn("lk2", 1'b1, 32'h600, 32'hB2);
        txn("lk3", 1'b0, 32'h500, 32'hB3);
`endif
        c_req = 1'b0; d_req = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
